// File: rtl/fetch_line_buffer_if.sv
// rtl/fetch_line_buffer_if.sv - bus request/response and decoder handshake bundle for fetch_line_buffer
interface fetch_line_buffer_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [63:0]               bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      inst_valid;
  logic [31:0]               inst_data;
  logic [63:0]               inst_pc;
  logic                      inst_ready;
  logic                      redirect_valid;
  logic [63:0]               redirect_pc;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output inst_valid, inst_data, inst_pc,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  inst_valid, inst_data, inst_pc,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - line-based instruction fetch: bus line reads into a 16-slot buffer, one instruction per cycle out
module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         entry,
  fetch_line_buffer_if.master bus,
  output logic                halted
);
  localparam int BEATS    = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int SLOTS    = LINE_BYTES / 4;
  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int SLOT_W   = OFF_BITS - 2;
  localparam int BEAT_W   = $clog2(BEATS);

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
    BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});

  typedef enum logic [1:0] {S_REQ, S_RECV, S_DRAIN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [63:0]         fetch_pc_q, fetch_pc_d;
  logic [63:0]         req_addr_q, req_addr_d;
  logic                reqcyc_q, reqcyc_d;
  logic                respack_q, respack_d;
  logic                halted_q, halted_d;
  logic                discard_q, discard_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                buf_we;
  logic [31:0]         line_buf [SLOTS];
  logic [SLOT_W-1:0]   slot;
  logic [31:0]         cur_word;
  logic                inst_valid;
  logic                unused_bits;

  // fetch_pc always tracks the next instruction, so its offset bits are the slot pointer
  assign slot     = fetch_pc_q[OFF_BITS-1:2];
  assign cur_word = line_buf[slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= entry;
      req_addr_q <= '0;
      reqcyc_q   <= 1'b0;
      respack_q  <= 1'b0;
      halted_q   <= 1'b0;
      discard_q  <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      reqcyc_q   <= reqcyc_d;
      respack_q  <= respack_d;
      halted_q   <= halted_d;
      discard_q  <= discard_d;
      beat_q     <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[{beat_q, 1'b0}] <= bus.bus_resp[31:0];
      line_buf[{beat_q, 1'b1}] <= bus.bus_resp[63:32];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    reqcyc_d   = 1'b0;
    respack_d  = 1'b0;
    halted_d   = halted_q;
    discard_d  = discard_q;
    beat_d     = beat_q;
    buf_we     = 1'b0;

    case (state_q)
      S_REQ: begin
        if (reqcyc_q && bus.bus_reqack) begin
          state_d = S_RECV;
          beat_d  = '0;
        end else begin
          reqcyc_d = 1'b1;
          // address is latched once so it holds steady even if fetch_pc is redirected mid-request
          if (!reqcyc_q) req_addr_d = {fetch_pc_q[63:OFF_BITS], {OFF_BITS{1'b0}}};
        end
      end
      S_RECV: begin
        if (bus.bus_respcyc) begin
          buf_we    = 1'b1;
          respack_d = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            discard_d = 1'b0;
            state_d   = discard_q ? S_REQ : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cur_word == 32'h0) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (bus.inst_ready) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          if (slot == SLOT_W'(SLOTS - 1)) state_d = S_REQ;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything except an in-flight bus transaction, which is finished and discarded
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      halted_d   = 1'b0;
      case (state_q)
        S_REQ: begin
          if (reqcyc_q) discard_d = 1'b1;
          else req_addr_d = {bus.redirect_pc[63:OFF_BITS], {OFF_BITS{1'b0}}};
        end
        S_RECV: begin
          if (bus.bus_respcyc && beat_q == BEAT_W'(BEATS - 1)) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign inst_valid      = (state_q == S_DRAIN) && (cur_word != 32'h0);
  assign bus.inst_valid  = inst_valid;
  assign bus.inst_data   = inst_valid ? cur_word : 32'h0;
  assign bus.inst_pc     = inst_valid ? {fetch_pc_q[63:2], 2'b00} : 64'h0;
  assign bus.bus_reqcyc  = reqcyc_q;
  assign bus.bus_req     = reqcyc_q ? req_addr_q : 64'h0;
  assign bus.bus_reqtag  = reqcyc_q ? REQ_TAG : '0;
  assign bus.bus_respack = respack_q;
  assign halted          = halted_q;

  assign unused_bits = ^{bus.bus_resptag, fetch_pc_q[1:0]};
endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb/tb_fetch_line_buffer.sv - directed self-checking bench for fetch_line_buffer
module tb_fetch_line_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        halted;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] zero_addr;

  fetch_line_buffer_if fl_if ();

  fetch_line_buffer dut (
    .clk    (clk),
    .reset  (reset),
    .entry  (entry),
    .bus    (fl_if),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return {a[17:2], 16'h0013};
  endfunction

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1;
    entry = e;
    @(negedge clk);
    check("rst_outputs", {57'h0, fl_if.bus_reqcyc, fl_if.bus_respack, fl_if.inst_valid, halted,
                          |fl_if.bus_req, |fl_if.inst_data, |fl_if.inst_pc}, 64'h0);
    reset = 1'b0;
  endtask

  task automatic wait_req(input logic [63:0] exp_addr);
    int n = 0;
    while (!fl_if.bus_reqcyc && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {63'h0, fl_if.bus_reqcyc}, 64'h1);
    check("req_addr", fl_if.bus_req, exp_addr);
    check("req_tag", {51'h0, fl_if.bus_reqtag}, 64'h1100);
    fl_if.bus_reqack = 1'b1;
    @(negedge clk);
    fl_if.bus_reqack = 1'b0;
    check("req_drop", {63'h0, fl_if.bus_reqcyc}, 64'h0);
  endtask

  task automatic send_beats(input logic [63:0] line, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      fl_if.bus_resp    = {word(line + 64'(8*k) + 64'd4), word(line + 64'(8*k))};
      fl_if.bus_respcyc = 1'b1;
      @(negedge clk);
      check($sformatf("beat_ack%0d", k), {63'h0, fl_if.bus_respack}, 64'h1);
    end
    fl_if.bus_respcyc = 1'b0;
  endtask

  task automatic drain(input logic [63:0] pc0, input int n);
    fl_if.inst_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("inst_valid", {63'h0, fl_if.inst_valid}, 64'h1);
      check("inst_pc", fl_if.inst_pc, pc0 + 64'(4*i));
      check("inst_data", {32'h0, fl_if.inst_data}, {32'h0, word(pc0 + 64'(4*i))});
      @(negedge clk);
    end
    fl_if.inst_ready = 1'b0;
  endtask

  initial begin
    logic        bad;
    logic [63:0] pc_hold;
    logic [31:0] data_hold;
    reset = 1'b1;
    entry = 64'h0;
    zero_addr = 64'h1;
    fl_if.bus_reqack = 1'b0;
    fl_if.bus_respcyc = 1'b0;
    fl_if.bus_resp = 64'h0;
    fl_if.bus_resptag = 13'h0;
    fl_if.inst_ready = 1'b0;
    fl_if.redirect_valid = 1'b0;
    fl_if.redirect_pc = 64'h0;

    // aligned line, full drain, next line request
    do_reset(64'h1000);
    wait_req(64'h1000);
    send_beats(64'h1000, 0, 7);
    drain(64'h1000, 16);
    check("respack_idle", {63'h0, fl_if.bus_respack}, 64'h0);
    wait_req(64'h1040);

    // unaligned entry skips earlier slots
    do_reset(64'h1008);
    wait_req(64'h1000);
    send_beats(64'h1000, 0, 7);
    drain(64'h1008, 14);
    wait_req(64'h1040);

    // zero word at slot 5 halts
    zero_addr = 64'h2014;
    do_reset(64'h2000);
    wait_req(64'h2000);
    send_beats(64'h2000, 0, 7);
    drain(64'h2000, 5);
    check("halt_novalid", {63'h0, fl_if.inst_valid}, 64'h0);
    bad = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (fl_if.bus_reqcyc || fl_if.inst_valid) bad = 1'b1;
    end
    check("halt_quiet", {63'h0, bad}, 64'h0);
    check("halted", {63'h0, halted}, 64'h1);
    fl_if.redirect_valid = 1'b1;
    fl_if.redirect_pc = 64'h1000;
    @(negedge clk);
    fl_if.redirect_valid = 1'b0;
    check("halt_clear", {63'h0, halted}, 64'h0);
    zero_addr = 64'h1;
    wait_req(64'h1000);

    // decoder stall mid-drain
    do_reset(64'h1000);
    wait_req(64'h1000);
    send_beats(64'h1000, 0, 7);
    drain(64'h1000, 3);
    pc_hold = 64'h100C;
    data_hold = word(64'h100C);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!fl_if.inst_valid || fl_if.inst_pc != pc_hold || fl_if.inst_data != data_hold || fl_if.bus_reqcyc)
        bad = 1'b1;
      @(negedge clk);
    end
    check("stall_stable", {63'h0, bad}, 64'h0);
    drain(64'h100C, 13);
    wait_req(64'h1040);

    // redirect during RECV: remaining beats acked and discarded
    do_reset(64'h1000);
    wait_req(64'h1000);
    send_beats(64'h1000, 0, 3);
    fl_if.redirect_valid = 1'b1;
    fl_if.redirect_pc = 64'h3004;
    @(negedge clk);
    fl_if.redirect_valid = 1'b0;
    send_beats(64'h1000, 4, 7);
    check("discard_novalid", {63'h0, fl_if.inst_valid}, 64'h0);
    wait_req(64'h3000);
    send_beats(64'h3000, 0, 7);
    drain(64'h3004, 2);

    // reset mid-RECV, stray beats ignored
    do_reset(64'h1000);
    wait_req(64'h1000);
    send_beats(64'h1000, 0, 2);
    fl_if.bus_respcyc = 1'b1;
    do_reset(64'h4000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_noack", {63'h0, fl_if.bus_respack}, 64'h0);
    end
    fl_if.bus_respcyc = 1'b0;
    wait_req(64'h4000);
    send_beats(64'h4000, 0, 7);
    drain(64'h4000, 2);

    // redirect from DRAIN to the top of the address space; line address wraps to 0
    fl_if.redirect_valid = 1'b1;
    fl_if.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    fl_if.redirect_valid = 1'b0;
    check("redir_novalid", {63'h0, fl_if.inst_valid}, 64'h0);
    wait_req(64'hFFFF_FFFF_FFFF_FFC0);
    send_beats(64'hFFFF_FFFF_FFFF_FFC0, 0, 7);
    drain(64'hFFFF_FFFF_FFFF_FFFC, 1);
    wait_req(64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Instruction-fetch front end between the system bus and the decoder.
- Issues 64-byte line reads on the bus and collects the 64-bit response beats into a 16-entry instruction buffer.
- Presents one 32-bit instruction per cycle, with its PC, to the decoder over a valid/ready handshake.
- Supports redirect from downstream and halts on an all-zero instruction word.

Parameters:
- BUS_DATA_WIDTH, 64, bus data width; fixed at 64 for this block.
- BUS_TAG_WIDTH, 13, bus tag width.
- LINE_BYTES, 64, bytes per line read; BEATS = LINE_BYTES*8/BUS_DATA_WIDTH = 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- entry  in  64  program entry PC, sampled in reset; 4-byte aligned
- bus_reqcyc  out  1  request valid; held until bus_reqack
- bus_req  out  64  line-aligned request address
- bus_reqtag  out  13  constant SYSBUS_READ<<12 | SYSBUS_MEMORY<<8
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  64  response beat data
- bus_resptag  in  13  response tag; ignored
- bus_respack  out  1  one-cycle ack per consumed beat
- inst_valid  out  1  instruction available
- inst_data  out  32  instruction word
- inst_pc  out  64  instruction address
- inst_ready  in  1  decoder accepts instruction
- redirect_valid  in  1  flush and refetch from redirect_pc
- redirect_pc  in  64  new PC; 4-byte aligned
- halted  out  1  end-of-program reached; sticky

Behaviour:
- Reset (clk edge with reset=1):
  - state=REQ; fetch_pc=entry.
  - All outputs 0, including bus_reqcyc, bus_respack, inst_valid and halted.
  - Buffer contents don't-care. Reset overrides everything, including a line mid-RECV; outstanding beats are not drained.
- State REQ:
  - bus_reqcyc=1; bus_req = {fetch_pc[63:6], 6'b0}.
  - Outputs held until bus_reqack=1 is sampled, then next cycle bus_reqcyc=0 and state=RECV with beat count=0.
- State RECV:
  - Each cycle bus_respcyc=1: write beat k to buffer slots 2k (bus_resp[31:0]) and 2k+1 (bus_resp[63:32]).
  - bus_respack=1 for the cycle following each beat; beat count +1.
  - After beat 7: state=DRAIN; slot index = fetch_pc[5:2], so an unaligned entry skips the earlier slots.
- State DRAIN:
  - inst_valid=1; inst_data = buffer[slot]; inst_pc = {fetch_pc[63:6], slot, 2'b00}.
  - On inst_valid & inst_ready: slot+1 and fetch_pc+4.
  - When slot 15 is accepted: fetch_pc = line+64, state=REQ. No prefetch; the next request starts the cycle after.
  - inst_valid, inst_data and inst_pc are stable while inst_ready=0.
- Halt:
  - In DRAIN, if buffer[slot]==32'h0: inst_valid=0, halted=1, state=HALT.
  - HALT is terminal; only reset or redirect leaves it. The zero word is never presented.
- Redirect (redirect_valid=1), highest priority after reset:
  - fetch_pc=redirect_pc; inst_valid=0 next cycle; halted cleared.
  - From DRAIN/HALT/IDLE-equivalent: state=REQ.
  - From REQ before ack: the current request is finished (held until ack), its beats are discarded, then a new REQ is issued.
  - From RECV: the remaining beats are still consumed and acked, the data is discarded, then REQ.
  - Implement with a sticky discard flag.
- Simultaneous redirect and inst_ready handshake: redirect wins; the accepted instruction is still considered consumed by the decoder.
- PC arithmetic: 64-bit, wraps modulo 2^64. Line address +64 wraps from 0xFFFF_FFFF_FFFF_FFC0 to 0.
- bus_respcyc outside RECV (or outside a discard drain) is ignored and not acked.

Test Plan:
- Entry=0x1000, memory words 0x00000013..: one request at 0x1000; 8 beats acked; 16 instructions out with inst_pc 0x1000..0x103C in order; then request at 0x1040.
- Entry=0x1008: request 0x1000; first inst_pc=0x1008; 14 instructions; then request 0x1040.
- Slot 5 of the line is 0 (entry=0x2000): 5 instructions 0x2000..0x2010 out, then halted=1, inst_valid=0, bus_reqcyc stays 0 for 20+ cycles.
- inst_ready held 0 for 10 cycles mid-DRAIN: inst_valid/inst_data/inst_pc unchanged; no bus request issued.
- redirect to 0x3004 after beat 3 of line 0x1000: beats 4–7 still acked, no instruction output; next request 0x3000; first inst_pc=0x3004.
- reset asserted mid-RECV with entry=0x4000: all outputs 0 the next cycle; new request 0x4000 issued; leftover beats ignored.
